// File: rtl/arith_result_display.sv
// Captures an 8-bit arithmetic result plus carry, converts it to BCD by double dabble,
// and scans it onto a 4-digit active-low seven-segment display. Define ARITH_DISP_HEX_EN to add a hex_mode input.
module arith_result_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] result,
  input  logic       cout,
`ifdef ARITH_DISP_HEX_EN
  input  logic       hex_mode,
`endif
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       led_cout
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_C     = 7'b1000110;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  iter_q, iter_d;
  logic [7:0]  shadow_q, shadow_d;
  logic        cout_sh_q, cout_sh_d;
  logic [7:0]  work_q, work_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  disp_h_q, disp_h_d;
  logic [3:0]  disp_t_q, disp_t_d;
  logic [3:0]  disp_o_q, disp_o_d;
  logic        led_q, led_d;
`ifdef ARITH_DISP_HEX_EN
  logic [7:0]  disp_bin_q, disp_bin_d;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic [11:0] bcd_adj;
  logic [7:0]  work_src;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] d);
    add3 = (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // The first step shifts straight out of the shadow so the captured value stays intact.
  assign work_src = (iter_q == 3'd0) ? shadow_q : work_q;
  assign bcd_adj  = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    shadow_d  = shadow_q;
    cout_sh_d = cout_sh_q;
    work_d    = work_q;
    bcd_d     = bcd_q;
    disp_h_d  = disp_h_q;
    disp_t_d  = disp_t_q;
    disp_o_d  = disp_o_q;
    led_d     = led_q;
`ifdef ARITH_DISP_HEX_EN
    disp_bin_d = disp_bin_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d   = ST_CONVERT;
          iter_d    = 3'd0;
          shadow_d  = result;
          cout_sh_d = cout;
          bcd_d     = '0;
        end
      end
      ST_CONVERT: begin
        {bcd_d, work_d} = {bcd_adj, work_src} << 1;
        iter_d          = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        disp_h_d = bcd_q[11:8];
        disp_t_d = bcd_q[7:4];
        disp_o_d = bcd_q[3:0];
        led_d    = cout_sh_q;
`ifdef ARITH_DISP_HEX_EN
        disp_bin_d = shadow_q;
`endif
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    idx_d = (cnt_q == CNT_LAST) ? idx_q + 2'd1 : idx_q;
    an_d  = ~(4'b0001 << idx_q);
    seg_d = SEG_BLANK;
    case (idx_q)
      2'd0: seg_d = glyph(disp_o_q);
      2'd1: seg_d = (disp_h_q == 4'd0 && disp_t_q == 4'd0) ? SEG_BLANK : glyph(disp_t_q);
      2'd2: seg_d = (disp_h_q == 4'd0) ? SEG_BLANK : glyph(disp_h_q);
      default: seg_d = led_q ? SEG_C : SEG_BLANK;
    endcase
`ifdef ARITH_DISP_HEX_EN
    if (hex_mode) begin
      case (idx_q)
        2'd0: seg_d = glyph(disp_bin_q[3:0]);
        2'd1: seg_d = glyph(disp_bin_q[7:4]);
        2'd2: seg_d = SEG_BLANK;
        default: seg_d = led_q ? SEG_C : SEG_BLANK;
      endcase
    end
`endif
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      iter_q    <= '0;
      shadow_q  <= '0;
      cout_sh_q <= 1'b0;
      work_q    <= '0;
      bcd_q     <= '0;
      disp_h_q  <= '0;
      disp_t_q  <= '0;
      disp_o_q  <= '0;
      led_q     <= 1'b0;
`ifdef ARITH_DISP_HEX_EN
      disp_bin_q <= '0;
`endif
      cnt_q     <= '0;
      idx_q     <= '0;
      seg_q     <= SEG_BLANK;
      an_q      <= 4'b1111;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      shadow_q  <= shadow_d;
      cout_sh_q <= cout_sh_d;
      work_q    <= work_d;
      bcd_q     <= bcd_d;
      disp_h_q  <= disp_h_d;
      disp_t_q  <= disp_t_d;
      disp_o_q  <= disp_o_d;
      led_q     <= led_d;
`ifdef ARITH_DISP_HEX_EN
      disp_bin_q <= disp_bin_d;
`endif
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign seg      = seg_q;
  assign an       = an_q;
  assign led_cout = led_q;

endmodule
